// File: rtl/axi4_lite_regfile_slave_if.sv
// AXI4-Lite bundle between an interconnect master and the register-file slave.
// clk/reset remain plain module ports; only the five channels live here.
interface axi4_lite_regfile_slave_if #(
    parameter int p_ADDRESS_WIDTH = 5,
    parameter int p_DATA_WIDTH    = 32
);
    localparam int lp_STROBE_WIDTH = p_DATA_WIDTH / 8;

    logic [p_ADDRESS_WIDTH-1:0] i_M_AWADDR;
    logic [2:0]                 i_M_AWPROT;
    logic                       i_M_AWVALID;
    logic                       o_S_AWREADY;

    logic [p_DATA_WIDTH-1:0]    i_M_WDATA;
    logic [lp_STROBE_WIDTH-1:0] i_M_WSTRB;
    logic                       i_M_WVALID;
    logic                       o_S_WREADY;

    logic [1:0]                 o_S_BRESP;
    logic                       o_S_BVALID;
    logic                       i_M_BREADY;

    logic [p_ADDRESS_WIDTH-1:0] i_M_ARADDR;
    logic [2:0]                 i_M_ARPROT;
    logic                       i_M_ARVALID;
    logic                       o_S_ARREADY;

    logic [p_DATA_WIDTH-1:0]    o_S_RDATA;
    logic [1:0]                 o_S_RRESP;
    logic                       o_S_RVALID;
    logic                       i_M_RREADY;

    modport slave (
        input  i_M_AWADDR, i_M_AWPROT, i_M_AWVALID,
        output o_S_AWREADY,
        input  i_M_WDATA, i_M_WSTRB, i_M_WVALID,
        output o_S_WREADY,
        output o_S_BRESP, o_S_BVALID,
        input  i_M_BREADY,
        input  i_M_ARADDR, i_M_ARPROT, i_M_ARVALID,
        output o_S_ARREADY,
        output o_S_RDATA, o_S_RRESP, o_S_RVALID,
        input  i_M_RREADY
    );

    modport master (
        output i_M_AWADDR, i_M_AWPROT, i_M_AWVALID,
        input  o_S_AWREADY,
        output i_M_WDATA, i_M_WSTRB, i_M_WVALID,
        input  o_S_WREADY,
        input  o_S_BRESP, o_S_BVALID,
        output i_M_BREADY,
        output i_M_ARADDR, i_M_ARPROT, i_M_ARVALID,
        input  o_S_ARREADY,
        input  o_S_RDATA, o_S_RRESP, o_S_RVALID,
        output i_M_RREADY
    );
endinterface

// File: rtl/axi4_lite_regfile_slave.sv
// AXI4-Lite slave over a bank of byte-writable registers, exported flat with
// per-register write pulses. AW and W are buffered independently and joined at commit.
module axi4_lite_regfile_slave #(
    parameter int p_ADDRESS_WIDTH = 5,
    parameter int p_DATA_WIDTH    = 32,
    parameter int p_NUM_REGS      = 6
) (
    input  logic                               i_ACLK,
    input  logic                               i_ARESETN,
    axi4_lite_regfile_slave_if.slave           s_axi,
    output logic [p_NUM_REGS*p_DATA_WIDTH-1:0] o_REGS,
    output logic [p_NUM_REGS-1:0]              o_REG_WR
);
    localparam int lp_STROBE_WIDTH = p_DATA_WIDTH / 8;
    localparam int lp_LSB          = $clog2(lp_STROBE_WIDTH);
    localparam int lp_IDX_W        = p_ADDRESS_WIDTH - lp_LSB;

    localparam logic [1:0] lp_OKAY   = 2'b00;
    localparam logic [1:0] lp_SLVERR = 2'b10;

    typedef logic [lp_IDX_W-1:0] idx_t;
    typedef logic [p_NUM_REGS-1:0][p_DATA_WIDTH-1:0] bank_t;

    function automatic logic idx_in_range(input idx_t idx);
        return 32'(idx) < 32'(p_NUM_REGS);
    endfunction

    logic                       gate_q,   gate_d;
    logic                       aw_full_q, aw_full_d;
    idx_t                       aw_idx_q,  aw_idx_d;
    logic                       w_full_q,  w_full_d;
    logic [p_DATA_WIDTH-1:0]    w_data_q,  w_data_d;
    logic [lp_STROBE_WIDTH-1:0] w_strb_q,  w_strb_d;
    logic                       bvalid_q,  bvalid_d;
    logic [1:0]                 bresp_q,   bresp_d;
    logic                       rvalid_q,  rvalid_d;
    logic [1:0]                 rresp_q,   rresp_d;
    logic [p_DATA_WIDTH-1:0]    rdata_q,   rdata_d;
    bank_t                      regs_q,    regs_d;
    logic [p_NUM_REGS-1:0]      reg_wr_q,  reg_wr_d;

    logic aw_ready, w_ready, ar_ready;
    logic aw_hs, w_hs, ar_hs, b_hs, r_hs;
    logic commit;
    logic wr_in_range, rd_in_range;
    idx_t aw_idx_in, ar_idx_in;

    // PROT and the sub-word address bits carry no meaning for this bank.
    logic unused_ok;
    assign unused_ok = ^{s_axi.i_M_AWPROT, s_axi.i_M_ARPROT,
                         s_axi.i_M_AWADDR[lp_LSB-1:0], s_axi.i_M_ARADDR[lp_LSB-1:0]};

    assign aw_idx_in = s_axi.i_M_AWADDR[p_ADDRESS_WIDTH-1:lp_LSB];
    assign ar_idx_in = s_axi.i_M_ARADDR[p_ADDRESS_WIDTH-1:lp_LSB];

    assign aw_ready = gate_q & ~aw_full_q;
    assign w_ready  = gate_q & ~w_full_q;
    assign ar_ready = gate_q & ~rvalid_q;

    assign aw_hs = s_axi.i_M_AWVALID & aw_ready;
    assign w_hs  = s_axi.i_M_WVALID  & w_ready;
    assign ar_hs = s_axi.i_M_ARVALID & ar_ready;
    assign b_hs  = bvalid_q & s_axi.i_M_BREADY;
    assign r_hs  = rvalid_q & s_axi.i_M_RREADY;

    // Gating on bvalid_q keeps a commit off the B-handshake edge.
    assign commit      = aw_full_q & w_full_q & ~bvalid_q;
    assign wr_in_range = idx_in_range(aw_idx_q);
    assign rd_in_range = idx_in_range(ar_idx_in);

    always_comb begin
        gate_d    = 1'b1;
        aw_full_d = aw_full_q;
        aw_idx_d  = aw_idx_q;
        w_full_d  = w_full_q;
        w_data_d  = w_data_q;
        w_strb_d  = w_strb_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        rvalid_d  = rvalid_q;
        rresp_d   = rresp_q;
        rdata_d   = rdata_q;
        regs_d    = regs_q;
        reg_wr_d  = '0;

        if (aw_hs) begin
            aw_full_d = 1'b1;
            aw_idx_d  = aw_idx_in;
        end else if (commit) begin
            aw_full_d = 1'b0;
        end

        if (w_hs) begin
            w_full_d = 1'b1;
            w_data_d = s_axi.i_M_WDATA;
            w_strb_d = s_axi.i_M_WSTRB;
        end else if (commit) begin
            w_full_d = 1'b0;
        end

        if (commit) begin
            bvalid_d = 1'b1;
            bresp_d  = wr_in_range ? lp_OKAY : lp_SLVERR;
            for (int k = 0; k < p_NUM_REGS; k++) begin
                if (wr_in_range && aw_idx_q == idx_t'(k)) begin
                    for (int b = 0; b < lp_STROBE_WIDTH; b++) begin
                        if (w_strb_q[b]) begin
                            regs_d[k][b*8 +: 8] = w_data_q[b*8 +: 8];
                        end
                    end
                    reg_wr_d[k] = |w_strb_q;
                end
            end
        end else if (b_hs) begin
            bvalid_d = 1'b0;
        end

        // Reads sample regs_q, so a same-edge write is not yet visible.
        if (ar_hs) begin
            rvalid_d = 1'b1;
            rresp_d  = rd_in_range ? lp_OKAY : lp_SLVERR;
            rdata_d  = '0;
            for (int k = 0; k < p_NUM_REGS; k++) begin
                if (ar_idx_in == idx_t'(k)) begin
                    rdata_d = regs_q[k];
                end
            end
        end else if (r_hs) begin
            rvalid_d = 1'b0;
        end
    end

    always_ff @(posedge i_ACLK or negedge i_ARESETN) begin
        if (!i_ARESETN) begin
            gate_q    <= 1'b0;
            aw_full_q <= 1'b0;
            aw_idx_q  <= '0;
            w_full_q  <= 1'b0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
            rvalid_q  <= 1'b0;
            rresp_q   <= 2'b00;
            rdata_q   <= '0;
            regs_q    <= '0;
            reg_wr_q  <= '0;
        end else begin
            gate_q    <= gate_d;
            aw_full_q <= aw_full_d;
            aw_idx_q  <= aw_idx_d;
            w_full_q  <= w_full_d;
            w_data_q  <= w_data_d;
            w_strb_q  <= w_strb_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            rvalid_q  <= rvalid_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
            regs_q    <= regs_d;
            reg_wr_q  <= reg_wr_d;
        end
    end

    assign s_axi.o_S_AWREADY = aw_ready;
    assign s_axi.o_S_WREADY  = w_ready;
    assign s_axi.o_S_ARREADY = ar_ready;
    assign s_axi.o_S_BVALID  = bvalid_q;
    assign s_axi.o_S_BRESP   = bresp_q;
    assign s_axi.o_S_RVALID  = rvalid_q;
    assign s_axi.o_S_RRESP   = rresp_q;
    assign s_axi.o_S_RDATA   = rdata_q;

    assign o_REGS   = regs_q;
    assign o_REG_WR = reg_wr_q;
endmodule
